feat_readback_streamer: RTL and testbench

- Reads finished new-feature words out of the feature BRAM through its read port (addrb -> dout, 1-cycle read latency) and streams them to the PS on a valid/ready stream with a last marker.
- Mirrors the PS-side BRAM load path: the PS loads H/weights in, and this block drains results back out after a GAT layer completes.
- Sits between the memory controller's feature-BRAM read port and the PS DMA.

---
 rtl/feat_readback_streamer.sv | 103 ++++++++++
 tb/tb_feat_readback_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/feat_readback_streamer.sv
// feat_readback_streamer: drains feature BRAM words to a valid/ready stream with a last marker
module feat_readback_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SUBGRAPHS = 2708,
  parameter int NUM_FEATURE_OUT = 16,
  localparam int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W-1:0] base_addr,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);
  localparam logic [NEW_FEATURE_ADDR_W:0] DEPTH_N = (NEW_FEATURE_ADDR_W+1)'(NEW_FEATURE_DEPTH);
  localparam logic [NEW_FEATURE_ADDR_W+1:0] DEPTH_S = (NEW_FEATURE_ADDR_W+2)'(NEW_FEATURE_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NEW_FEATURE_ADDR_W-1:0] base_q, addr_q, addr_wrap;
  logic [NEW_FEATURE_ADDR_W:0] num_q, issue_q, num_cap;
  logic [NEW_FEATURE_ADDR_W+1:0] addr_sum;
  logic inflight_q, inflight_last_q, issue, push, pop, accept;
  logic [1:0] cnt_q, cnt_d, wr_idx;
  logic [DATA_WIDTH-1:0] d0_q, d1_q, d0_d, d1_d;
  logic l0_q, l1_q, l0_d, l1_d;
  assign m_tvalid = cnt_q != 2'd0;
  assign m_tdata = d0_q;
  assign m_tlast = l0_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pop = m_tvalid & m_tready;
  assign push = inflight_q;
  assign accept = state_q == IDLE && start;
  assign num_cap = num_words > DEPTH_N ? DEPTH_N : num_words;
  assign addr_sum = {2'b0, base_q} + {1'b0, issue_q};
  assign addr_wrap = NEW_FEATURE_ADDR_W'(addr_sum >= DEPTH_S ? addr_sum - DEPTH_S : addr_sum);
  assign issue = state_q == RUN && issue_q < num_q &&
                 ({1'b0, cnt_q} + {2'b0, inflight_q}) <= ({2'b0, pop} + 3'd1);
  assign feat_bram_addrb = issue ? addr_wrap : addr_q;
  assign wr_idx = cnt_q - {1'b0, pop};
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  always_comb begin
    state_d = state_q;
    if (accept) state_d = num_words == '0 ? DONE : RUN;
    else if (state_q == RUN && pop && m_tlast) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    d0_d = pop ? d1_q : d0_q;
    l0_d = pop ? l1_q : l0_q;
    d1_d = d1_q;
    l1_d = l1_q;
    if (push && wr_idx == 2'd0) begin
      d0_d = feat_bram_dout;
      l0_d = inflight_last_q;
    end
    if (push && wr_idx == 2'd1) begin
      d1_d = feat_bram_dout;
      l1_d = inflight_last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      num_q <= '0;
      issue_q <= '0;
      addr_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      cnt_q <= 2'd0;
      d0_q <= '0;
      d1_q <= '0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= feat_bram_addrb;
      inflight_q <= issue;
      inflight_last_q <= issue && issue_q == num_q - 1'b1;
      cnt_q <= cnt_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      l0_q <= l0_d;
      l1_q <= l1_d;
      if (accept) begin
        base_q <= base_addr;
        num_q <= num_cap;
        issue_q <= '0;
      end else if (issue) begin
        issue_q <= issue_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_feat_readback_streamer.sv
// tb_feat_readback_streamer: directed bench with a queue model of the expected word stream
module tb_feat_readback_streamer;
  localparam int DEPTH = 2708 * 16;
  logic clk = 0, rst = 1, start = 0, m_tready = 1;
  logic [15:0] base_addr = 0;
  logic [16:0] num_words = 0;
  logic busy, done, m_tvalid, m_tlast;
  logic [15:0] feat_bram_addrb;
  logic [7:0] feat_bram_dout = 0, m_tdata;
  int vecs = 0, fails = 0, cyc = 0, done_cnt = 0, beat_cnt = 0, rdy_mode = 0;
  int beat_cyc[$];
  logic [7:0] beat_dat[$];
  logic [8:0] exp_q[$];
  logic pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = 0;

  feat_readback_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) feat_bram_dout <= feat_bram_addrb[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int b, input int n, output int t0);
    int nn;
    nn = n > DEPTH ? DEPTH : n;
    for (int k = 0; k < nn; k++) exp_q.push_back({k == nn - 1, 8'((b + k) % DEPTH)});
    base_addr = 16'(b);
    num_words = 17'(n);
    start = 1;
    t0 = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int d0;
    d0 = done_cnt;
    dc = -1;
    for (int i = 0; i < budget && dc < 0; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        chk("busy_at_done", busy, 0);
      end
    end
    tick();
    chk("done_seen", done_cnt - d0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", m_tlast, pl);
      end
      if (done) begin
        done_cnt++;
        chk("tvalid_at_done", m_tvalid, 0);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
        else chk("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        beat_cyc.push_back(cyc);
        beat_dat.push_back(m_tdata);
        beat_cnt++;
      end
      pv = m_tvalid;
      pr = m_tready;
      pd = m_tdata;
      pl = m_tlast;
    end
  end

  initial begin
    int t0, dc, b0, d0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_addrb", feat_bram_addrb, 0);
    rst = 0;
    tick();

    b0 = beat_cnt;
    start_xfer(0, 16, t0);
    chk("basic_busy", busy, 1);
    wait_done(40, dc);
    chk("basic_done_cyc", dc, t0 + 19);
    chk("basic_count", beat_cnt - b0, 16);
    chk("basic_first_cyc", beat_cyc[b0], t0 + 3);
    chk("basic_last_cyc", beat_cyc[b0 + 15], t0 + 18);
    chk("basic_first_data", beat_dat[b0], 0);
    chk("basic_drained", exp_q.size(), 0);

    rdy_mode = 1;
    b0 = beat_cnt;
    start_xfer(100, 8, t0);
    wait_done(80, dc);
    rdy_mode = 0;
    chk("bp_count", beat_cnt - b0, 8);
    chk("bp_first_data", beat_dat[b0], 100);
    chk("bp_last_data", beat_dat[b0 + 7], 107);
    chk("bp_drained", exp_q.size(), 0);

    b0 = beat_cnt;
    start_xfer(43326, 4, t0);
    wait_done(30, dc);
    chk("wrap_count", beat_cnt - b0, 4);
    chk("wrap_beat1", beat_dat[b0 + 1], 8'h3f);
    chk("wrap_beat2", beat_dat[b0 + 2], 0);
    chk("wrap_beat3", beat_dat[b0 + 3], 1);

    b0 = beat_cnt;
    d0 = done_cnt;
    start_xfer(0, 0, t0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_tvalid", m_tvalid, 0);
    tick();
    @(negedge clk);
    chk("zero_done_off", done, 0);
    chk("zero_busy_off", busy, 0);
    tick();
    chk("zero_done_cnt", done_cnt - d0, 1);
    chk("zero_beats", beat_cnt - b0, 0);

    b0 = beat_cnt;
    d0 = done_cnt;
    start_xfer(200, 6, t0);
    repeat (3) tick();
    base_addr = 500;
    num_words = 3;
    start = 1;
    tick();
    start = 0;
    wait_done(40, dc);
    repeat (10) tick();
    chk("ign_done_cnt", done_cnt - d0, 1);
    chk("ign_count", beat_cnt - b0, 6);
    chk("ign_drained", exp_q.size(), 0);

    b0 = beat_cnt;
    start_xfer(0, 16, t0);
    for (int i = 0; i < 40 && beat_cnt - b0 < 5; i++) tick();
    chk("mid_beats_before_rst", beat_cnt - b0, 5);
    rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
    d0 = done_cnt;
    chk("mid_tvalid", m_tvalid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    repeat (5) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    b0 = beat_cnt;
    start_xfer(0, 2, t0);
    wait_done(20, dc);
    chk("mid_restart_count", beat_cnt - b0, 2);
    chk("mid_restart_d0", beat_dat[b0], 0);
    chk("mid_restart_d1", beat_dat[b0 + 1], 1);
    chk("mid_restart_done_cyc", dc, t0 + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
